// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous word memory between instruction fetch and data read/write.
// Fixed priority (write > read > fetch) with a starvation guard that forces a fetch grant.
module mem_arbiter #(
  parameter int MEM_WORDS    = 524288,
  parameter int MEM_AW       = $clog2(MEM_WORDS),
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IMEM_ARVALID,
  input  logic [31:0]       IMEM_ARADDR,
  output logic              IMEM_ARREADY,
  output logic              IMEM_RVALID,
  output logic [31:0]       IMEM_RDATA,
  input  logic              DMEM_ARVALID,
  input  logic [31:0]       DMEM_ARADDR,
  output logic              DMEM_ARREADY,
  output logic              DMEM_RVALID,
  output logic [31:0]       DMEM_RDATA,
  input  logic              DMEM_AWVALID,
  input  logic [31:0]       DMEM_AWADDR,
  input  logic [31:0]       DMEM_WDATA,
  input  logic [3:0]        DMEM_WSTRB,
  output logic              DMEM_AWREADY,
  output logic              DMEM_BVALID,
  output logic              DMEM_ERR,
  output logic              MEM_EN,
  output logic [3:0]        MEM_WE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA
);

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [1:0] DST_IMEM = 2'd0;
  localparam logic [1:0] DST_DRD  = 2'd1;
  localparam logic [1:0] DST_DWR  = 2'd2;

  // Any address bit above the word-addressable range marks the access as out of range.
  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr >> (MEM_AW + 2)) != 32'd0;
  endfunction

  logic [3:0]  starve_q, starve_d;
  logic        tag_vld_q, tag_vld_d;
  logic [1:0]  tag_dst_q, tag_dst_d;
  logic        tag_err_q, tag_err_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        force_i_s, gnt_i_s, gnt_r_s, gnt_w_s, gnt_any_s, oor_s;
  logic [31:0] gnt_addr_s;
  logic [31:0] ret_data_s;

  // Grant selection, memory drive and next-state for the starvation counter and owner tag.
  always_comb begin
    force_i_s    = IMEM_ARVALID && (starve_q == LIMIT);
    gnt_w_s      = !RST && !force_i_s && DMEM_AWVALID;
    gnt_r_s      = !RST && !force_i_s && !DMEM_AWVALID && DMEM_ARVALID;
    gnt_i_s      = !RST && IMEM_ARVALID && (force_i_s || (!DMEM_AWVALID && !DMEM_ARVALID));
    gnt_any_s    = gnt_w_s || gnt_r_s || gnt_i_s;
    gnt_addr_s   = 32'd0;
    tag_dst_d    = DST_IMEM;
    if (gnt_w_s) begin
      gnt_addr_s = DMEM_AWADDR;
      tag_dst_d  = DST_DWR;
    end else if (gnt_r_s) begin
      gnt_addr_s = DMEM_ARADDR;
      tag_dst_d  = DST_DRD;
    end else begin
      gnt_addr_s = IMEM_ARADDR;
      tag_dst_d  = DST_IMEM;
    end
    oor_s        = out_of_range(gnt_addr_s);
    IMEM_ARREADY = gnt_i_s;
    DMEM_ARREADY = gnt_r_s;
    DMEM_AWREADY = gnt_w_s;
    MEM_EN       = gnt_any_s && !oor_s;
    MEM_WE       = (gnt_w_s && !oor_s) ? DMEM_WSTRB : 4'd0;
    MEM_ADDR     = gnt_addr_s[MEM_AW+1:2];
    MEM_WDATA    = gnt_w_s ? DMEM_WDATA : 32'd0;
    tag_vld_d    = gnt_any_s;
    tag_err_d    = gnt_any_s && oor_s;
    starve_d     = starve_q;
    if (!IMEM_ARVALID || gnt_i_s) begin
      starve_d = 4'd0;
    end else if ((gnt_w_s || gnt_r_s) && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Response pulses from the owner tag; the non-addressed read port keeps its last data.
  always_comb begin
    ret_data_s  = tag_err_q ? 32'd0 : MEM_RDATA;
    IMEM_RVALID = !RST && tag_vld_q && (tag_dst_q == DST_IMEM);
    DMEM_RVALID = !RST && tag_vld_q && (tag_dst_q == DST_DRD);
    DMEM_BVALID = !RST && tag_vld_q && (tag_dst_q == DST_DWR);
    DMEM_ERR    = (DMEM_RVALID || DMEM_BVALID) && tag_err_q;
    IMEM_RDATA  = IMEM_RVALID ? ret_data_s : irdata_q;
    DMEM_RDATA  = DMEM_RVALID ? ret_data_s : drdata_q;
    irdata_d    = IMEM_RDATA;
    drdata_d    = DMEM_RDATA;
  end

  // State registers; reset also drops any grant still in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q  <= 4'd0;
      tag_vld_q <= 1'b0;
      tag_dst_q <= DST_IMEM;
      tag_err_q <= 1'b0;
      irdata_q  <= 32'd0;
      drdata_q  <= 32'd0;
    end else begin
      starve_q  <= starve_d;
      tag_vld_q <= tag_vld_d;
      tag_dst_q <= tag_dst_d;
      tag_err_q <= tag_err_d;
      irdata_q  <= irdata_d;
      drdata_q  <= drdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1024-word behavioural memory behind it.
module tb_mem_arbiter;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IMEM_ARVALID, IMEM_ARREADY, IMEM_RVALID;
  logic [31:0]   IMEM_ARADDR, IMEM_RDATA;
  logic          DMEM_ARVALID, DMEM_ARREADY, DMEM_RVALID;
  logic [31:0]   DMEM_ARADDR, DMEM_RDATA;
  logic          DMEM_AWVALID, DMEM_AWREADY, DMEM_BVALID, DMEM_ERR;
  logic [31:0]   DMEM_AWADDR, DMEM_WDATA;
  logic [3:0]    DMEM_WSTRB;
  logic          MEM_EN;
  logic [3:0]    MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_WDATA, MEM_RDATA;

  logic [31:0] mem [0:1023];
  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.MEM_WORDS(1024), .MEM_AW(AW), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_ARVALID(IMEM_ARVALID), .IMEM_ARADDR(IMEM_ARADDR), .IMEM_ARREADY(IMEM_ARREADY),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .DMEM_ARVALID(DMEM_ARVALID), .DMEM_ARADDR(DMEM_ARADDR), .DMEM_ARREADY(DMEM_ARREADY),
    .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_AWVALID(DMEM_AWVALID), .DMEM_AWADDR(DMEM_AWADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_WSTRB(DMEM_WSTRB), .DMEM_AWREADY(DMEM_AWREADY), .DMEM_BVALID(DMEM_BVALID),
    .DMEM_ERR(DMEM_ERR),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  // Single-port synchronous memory: byte-lane writes, registered read when no lanes are enabled.
  always @(posedge CLK) begin
    if (MEM_EN) begin
      for (int b = 0; b < 4; b++)
        if (MEM_WE[b]) mem[MEM_ADDR][8*b +: 8] <= MEM_WDATA[8*b +: 8];
      if (MEM_WE == 4'd0) MEM_RDATA <= mem[MEM_ADDR];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    IMEM_ARVALID = 1'b0; DMEM_ARVALID = 1'b0; DMEM_AWVALID = 1'b0;
  endtask

  task automatic dread(input logic [31:0] a, input logic [31:0] exp_data, input logic exp_err, input string tag);
    DMEM_ARVALID = 1'b1; DMEM_ARADDR = a;
    #1 chk({tag, "_arready"}, {31'd0, DMEM_ARREADY}, 32'd1);
    chk({tag, "_mem_en"}, {31'd0, MEM_EN}, {31'd0, !exp_err});
    tick();
    DMEM_ARVALID = 1'b0;
    #1 chk({tag, "_rvalid"}, {31'd0, DMEM_RVALID}, 32'd1);
    chk({tag, "_rdata"}, DMEM_RDATA, exp_data);
    chk({tag, "_err"}, {31'd0, DMEM_ERR}, {31'd0, exp_err});
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic exp_en, input logic exp_err, input string tag);
    DMEM_AWVALID = 1'b1; DMEM_AWADDR = a; DMEM_WDATA = d; DMEM_WSTRB = s;
    #1 chk({tag, "_awready"}, {31'd0, DMEM_AWREADY}, 32'd1);
    chk({tag, "_mem_en"}, {31'd0, MEM_EN}, {31'd0, exp_en});
    chk({tag, "_mem_we"}, {28'd0, MEM_WE}, exp_en ? {28'd0, s} : 32'd0);
    tick();
    DMEM_AWVALID = 1'b0;
    #1 chk({tag, "_bvalid"}, {31'd0, DMEM_BVALID}, 32'd1);
    chk({tag, "_err"}, {31'd0, DMEM_ERR}, {31'd0, exp_err});
  endtask

  initial begin
    logic exp_i, prev_i;
    for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
    mem[0]   = 32'h0000_0013;
    mem[128] = 32'h1122_3344;
    RST = 1'b1; idle();
    IMEM_ARADDR = 32'd0; DMEM_ARADDR = 32'd0; DMEM_AWADDR = 32'd0;
    DMEM_WDATA = 32'd0; DMEM_WSTRB = 4'd0;
    tick(); tick();
    IMEM_ARVALID = 1'b1;
    #1 chk("rst_imem_arready", {31'd0, IMEM_ARREADY}, 32'd0);
    chk("rst_mem_en", {31'd0, MEM_EN}, 32'd0);
    chk("rst_rvalids", {29'd0, IMEM_RVALID, DMEM_RVALID, DMEM_BVALID}, 32'd0);

    // Fetch accepted, then reset lands before its response
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("mid_arready", {31'd0, IMEM_ARREADY}, 32'd1);
    tick();
    RST = 1'b1; IMEM_ARVALID = 1'b0;
    #1 chk("mid_rvalid_rst", {31'd0, IMEM_RVALID}, 32'd0);
    tick();
    RST = 1'b0;
    #1 chk("mid_rvalid_after", {31'd0, IMEM_RVALID}, 32'd0);
    tick();

    // Single fetch
    IMEM_ARVALID = 1'b1; IMEM_ARADDR = 32'd0;
    #1 chk("fetch_arready", {31'd0, IMEM_ARREADY}, 32'd1);
    chk("fetch_mem_addr", {22'd0, MEM_ADDR}, 32'd0);
    tick();
    IMEM_ARVALID = 1'b0;
    #1 chk("fetch_rvalid", {31'd0, IMEM_RVALID}, 32'd1);
    chk("fetch_rdata", IMEM_RDATA, 32'h0000_0013);
    tick();
    chk("fetch_rvalid_pulse", {31'd0, IMEM_RVALID}, 32'd0);
    chk("fetch_rdata_hold", IMEM_RDATA, 32'h0000_0013);

    // All three request together: write, then read, then fetch
    IMEM_ARVALID = 1'b1; IMEM_ARADDR = 32'd0;
    DMEM_ARVALID = 1'b1; DMEM_ARADDR = 32'h100;
    DMEM_AWVALID = 1'b1; DMEM_AWADDR = 32'h100; DMEM_WDATA = 32'hDEAD_BEEF; DMEM_WSTRB = 4'hF;
    #1 chk("wr_first_readies", {29'd0, DMEM_AWREADY, DMEM_ARREADY, IMEM_ARREADY}, 32'd4);
    chk("wr_first_addr", {22'd0, MEM_ADDR}, 32'h40);
    chk("wr_first_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    tick();
    DMEM_AWVALID = 1'b0;
    #1 chk("wr_bvalid", {31'd0, DMEM_BVALID}, 32'd1);
    chk("rd_second_readies", {29'd0, DMEM_AWREADY, DMEM_ARREADY, IMEM_ARREADY}, 32'd2);
    chk("rd_second_we", {28'd0, MEM_WE}, 32'd0);
    tick();
    DMEM_ARVALID = 1'b0;
    #1 chk("rd_after_wr_rdata", DMEM_RDATA, 32'hDEAD_BEEF);
    chk("fetch_third_ready", {31'd0, IMEM_ARREADY}, 32'd1);
    tick();
    IMEM_ARVALID = 1'b0;
    #1 chk("fetch_third_rdata", IMEM_RDATA, 32'h0000_0013);
    tick();

    // Byte strobe merge
    dwrite(32'h200, 32'hAABB_CCDD, 4'h2, 1'b1, 1'b0, "strb_wr");
    tick();
    dread(32'h200, 32'h1122_CC44, 1'b0, "strb_rd");
    tick();

    // Starvation guard: four data grants then one fetch, repeating
    IMEM_ARVALID = 1'b1; IMEM_ARADDR = 32'd0;
    DMEM_ARVALID = 1'b1; DMEM_ARADDR = 32'h100;
    prev_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_i = (i % 5) == 4;
      #1 chk($sformatf("starve_i%0d", i), {31'd0, IMEM_ARREADY}, {31'd0, exp_i});
      chk($sformatf("starve_d%0d", i), {31'd0, DMEM_ARREADY}, {31'd0, !exp_i});
      if (i > 0) chk($sformatf("starve_rv%0d", i), {30'd0, IMEM_RVALID, DMEM_RVALID}, prev_i ? 32'd2 : 32'd1);
      prev_i = exp_i;
      tick();
    end
    idle();
    tick();

    // Out-of-range read and write; word 0 aliases the dropped write
    dread(32'h0000_1000, 32'd0, 1'b1, "oor_rd");
    tick();
    dwrite(32'h0000_1000, 32'h5555_5555, 4'hF, 1'b0, 1'b1, "oor_wr");
    tick();
    dread(32'h0, 32'h0000_0013, 1'b0, "oor_unchanged");
    tick();

    // Zero-strobe write still completes and leaves data intact
    dwrite(32'h100, 32'h0, 4'h0, 1'b1, 1'b0, "zstrb_wr");
    tick();
    dread(32'h100, 32'hDEAD_BEEF, 1'b0, "zstrb_rd");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous word memory between the core's instruction-fetch port and its data read/write ports.
- Sits between `core` (IMEM_*/DMEM_* buses) and the memory array or memory model.
- Uses fixed priority with a starvation guard for instruction fetch.
- Read latency is one cycle; requests may be accepted back-to-back.

Parameters:
- MEM_WORDS, 524288, depth of the backing memory in 32-bit words.
- MEM_AW, $clog2(MEM_WORDS), word-address width on the memory side.
- STARVE_LIMIT, 4, maximum consecutive data-side grants while IMEM is waiting before IMEM is forced a grant (range 1..15).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- IMEM_ARVALID  in  1  instruction read request.
- IMEM_ARADDR  in  32  instruction byte address.
- IMEM_ARREADY  out  1  request accepted this cycle (combinational grant).
- IMEM_RVALID  out  1  instruction data valid, one-cycle pulse.
- IMEM_RDATA  out  32  instruction data.
- DMEM_ARVALID  in  1  data read request.
- DMEM_ARADDR  in  32  data read byte address.
- DMEM_ARREADY  out  1  data read accepted this cycle.
- DMEM_RVALID  out  1  data read valid, one-cycle pulse.
- DMEM_RDATA  out  32  read data.
- DMEM_AWVALID  in  1  data write request.
- DMEM_AWADDR  in  32  write byte address.
- DMEM_WDATA  in  32  write data.
- DMEM_WSTRB  in  4  byte-lane enables.
- DMEM_AWREADY  out  1  write accepted this cycle.
- DMEM_BVALID  out  1  write response, one-cycle pulse.
- DMEM_ERR  out  1  out-of-range flag, qualified by DMEM_RVALID or DMEM_BVALID.
- MEM_EN  out  1  memory access enable.
- MEM_WE  out  4  per-byte write enable (0 = read).
- MEM_ADDR  out  MEM_AW  word address.
- MEM_WDATA  out  32  write data.
- MEM_RDATA  in  32  read data, valid the cycle after a read enable.

Behaviour:
Reset (RST=1 at a clock edge):
- All *_RVALID, DMEM_BVALID and DMEM_ERR are 0.
- MEM_EN=0, MEM_WE=0; starvation counter is 0; the return pipeline is flushed.
- Any grant in flight is dropped; no RVALID or BVALID for it ever appears.
- All READY outputs are 0 while RST=1.

Handshake:
- A requester holds VALID and its address/data stable until READY=1 in the same cycle.
- READY never asserts without VALID.
- At most one READY per cycle.
- R and B channels have no backpressure; requesters must take the pulse.

Arbitration (combinational, each cycle):
- Base priority: DMEM write > DMEM read > IMEM.
  - Write before read preserves store-then-load ordering to the same address.
- Starvation counter S:
  - Increments on each data-side grant while IMEM_ARVALID=1.
  - Clears on an IMEM grant or when IMEM_ARVALID=0.
  - Saturates at STARVE_LIMIT.
- When S==STARVE_LIMIT and IMEM_ARVALID=1, IMEM wins regardless of data requests.

Memory drive (same cycle as grant):
- MEM_EN=1 and MEM_ADDR = granted_addr[MEM_AW+1:2]; address bits [1:0] are ignored.
- Write: MEM_WE=DMEM_WSTRB and MEM_WDATA=DMEM_WDATA.
- Read: MEM_WE=0.

Range check:
- An address is out of range if any bit [31:MEM_AW+2] is nonzero.
- Such requests are still accepted, but MEM_EN=0 (writes dropped, no memory access).
- Reads return RDATA=0; DMEM_ERR=1 with the response.
- An out-of-range IMEM read returns 0; there is no IMEM error flag.

Return path:
- A registered owner tag {valid, dest, err} is captured at grant.
- Next cycle, exactly one of IMEM_RVALID, DMEM_RVALID or DMEM_BVALID pulses for one cycle.
- RDATA = MEM_RDATA, or 0 on error.
- The RDATA of the non-addressed port holds its last value.
- Throughput: one access per cycle; accept at cycle N produces its response at N+1 while a new accept at N+1 is legal.

Other rules:
- Simultaneous VALID on all three ports: only the priority winner is granted; losers keep VALID and are not lost.
- DMEM_WSTRB=0 write: accepted, MEM_EN=1 with MEM_WE=0; BVALID still pulses.

Test Plan:
- Reset mid-read: IMEM read to 0x0 accepted, RST=1 next cycle → IMEM_RVALID stays 0; all outputs 0 during reset.
- Single fetch: memory word 0 = 0x00000013, IMEM_ARADDR=0x0 → IMEM_ARREADY same cycle, IMEM_RVALID with 0x00000013 one cycle later.
- Write-then-read ordering: DMEM_AWVALID (addr 0x100, data 0xDEADBEEF, WSTRB=0xF) and DMEM_ARVALID (addr 0x100) in the same cycle → write granted first; read granted next cycle; DMEM_RDATA=0xDEADBEEF.
- Byte strobe: word 0x200 = 0x11223344, write 0xAABBCCDD with WSTRB=0x2 → subsequent read returns 0x1122CC44.
- Starvation guard: STARVE_LIMIT=4, IMEM_ARVALID and DMEM_ARVALID held high continuously → four DMEM grants, then one IMEM grant; the pattern repeats.
- Out of range: MEM_WORDS=1024, DMEM read at 0x00001000 → accepted, MEM_EN=0, DMEM_RVALID=1 with DMEM_RDATA=0 and DMEM_ERR=1; a write there leaves the memory unchanged and gives DMEM_BVALID=1 with DMEM_ERR=1.
